div_arbiter: RTL and testbench

Shares the single iterative divider between the two EXM_stage lanes of the dual-issue pipeline. Each lane presents its divide request on its existing es-to-div bus. The arbiter grants one lane at a time, launches the divider, and captures the result in a per-lane buffer. It then holds that lane's `ok` high until the instruction pair retires or is flushed.

---
 rtl/div_arbiter_pkg.sv | 15 +
 rtl/div_arbiter_lane_buf.sv | 27 ++
 rtl/div_arbiter.sv | 143 ++++++++++++++
 tb/tb_div_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_arbiter_pkg.sv
// Shared definitions for the divider arbiter: bus widths and FSM state encoding.
// The bus widths match the default 32-bit datapath.
package div_arbiter_pkg;

  localparam int ES_TO_DIV_BUS_MD = 67;
  localparam int DIV_TO_ES_BUS_MD = 33;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY0 = 2'b01,
    BUSY1 = 2'b10,
    DRAIN = 2'b11
  } arb_state_t;

endpackage

// File: rtl/div_arbiter_lane_buf.sv
// One lane's response buffer: a done flag and the captured divider result.
// A capture in the same cycle as a clear wins, so a fresh result is never lost.
module div_arbiter_lane_buf #(
  parameter int DATA_WD = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               capture,
  input  logic               clear,
  input  logic [DATA_WD-1:0] din,
  output logic               done,
  output logic [DATA_WD-1:0] res
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done <= 1'b0;
      res  <= '0;
    end else if (capture) begin
      done <= 1'b1;
      res  <= din;
    end else if (clear) begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative divider between the two EX lanes; fixed priority to lane 0,
// results are buffered per lane and ok is held until the pair advances or flushes.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int DATA_WD = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2*DATA_WD+2:0]   es0_to_div_bus,
  input  logic [2*DATA_WD+2:0]   es1_to_div_bus,
  output logic [DATA_WD:0]       div_to_es0_bus,
  output logic [DATA_WD:0]       div_to_es1_bus,
  input  logic                   advance,
  input  logic                   flush,
  output logic                   div_start,
  output logic                   div_mod,
  output logic                   div_unsigned,
  output logic [DATA_WD-1:0]     div_src1,
  output logic [DATA_WD-1:0]     div_src2,
  input  logic                   div_done,
  input  logic [DATA_WD-1:0]     div_result
);

  logic               valid0, mod0, uns0;
  logic               valid1, mod1, uns1;
  logic [DATA_WD-1:0] src1_0, src2_0, src1_1, src2_1;

  assign {valid0, mod0, uns0, src1_0, src2_0} = es0_to_div_bus;
  assign {valid1, mod1, uns1, src1_1, src2_1} = es1_to_div_bus;

  arb_state_t         state, next_state;
  logic               done0, done1;
  logic [DATA_WD-1:0] res0, res1;
  logic               req0, req1;
  logic               launch0, launch1;
  logic               cap0, cap1;
  logic               kill_done;

  assign kill_done = advance || flush;
  assign req0 = valid0 && !done0 && !kill_done;
  assign req1 = valid1 && !done1 && !kill_done;

  // A finishing lane hands the divider straight to a waiting peer to save the IDLE cycle.
  always_comb begin
    next_state = state;
    launch0    = 1'b0;
    launch1    = 1'b0;
    cap0       = 1'b0;
    cap1       = 1'b0;
    case (state)
      IDLE: begin
        if (req0) begin
          next_state = BUSY0;
          launch0    = 1'b1;
        end else if (req1) begin
          next_state = BUSY1;
          launch1    = 1'b1;
        end
      end
      BUSY0: begin
        if (flush) begin
          next_state = div_done ? IDLE : DRAIN;
        end else if (div_done) begin
          cap0 = 1'b1;
          if (req1) begin
            next_state = BUSY1;
            launch1    = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      BUSY1: begin
        if (flush) begin
          next_state = div_done ? IDLE : DRAIN;
        end else if (div_done) begin
          cap1 = 1'b1;
          if (req0) begin
            next_state = BUSY0;
            launch0    = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      DRAIN: begin
        if (div_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operands are latched only on launch so they stay stable for the whole divide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      div_start    <= 1'b0;
      div_mod      <= 1'b0;
      div_unsigned <= 1'b0;
      div_src1     <= '0;
      div_src2     <= '0;
    end else begin
      state     <= next_state;
      div_start <= launch0 || launch1;
      if (launch0) begin
        div_mod      <= mod0;
        div_unsigned <= uns0;
        div_src1     <= src1_0;
        div_src2     <= src2_0;
      end else if (launch1) begin
        div_mod      <= mod1;
        div_unsigned <= uns1;
        div_src1     <= src1_1;
        div_src2     <= src2_1;
      end
    end
  end

  div_arbiter_lane_buf #(.DATA_WD(DATA_WD)) u_lane_buf0 (
    .clk     (clk),
    .reset   (reset),
    .capture (cap0),
    .clear   (kill_done),
    .din     (div_result),
    .done    (done0),
    .res     (res0)
  );

  div_arbiter_lane_buf #(.DATA_WD(DATA_WD)) u_lane_buf1 (
    .clk     (clk),
    .reset   (reset),
    .capture (cap1),
    .clear   (kill_done),
    .din     (div_result),
    .done    (done1),
    .res     (res1)
  );

  assign div_to_es0_bus = {res0, done0};
  assign div_to_es1_bus = {res1, done1};

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with an 8-cycle divider model; expected values are
// hand-computed constants.
module tb_div_arbiter;
  import div_arbiter_pkg::*;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [ES_TO_DIV_BUS_MD-1:0] es0_to_div_bus, es1_to_div_bus;
  logic [DIV_TO_ES_BUS_MD-1:0] div_to_es0_bus, div_to_es1_bus;
  logic                        advance, flush;
  logic                        div_start, div_mod, div_unsigned, div_done;
  logic [31:0]                 div_src1, div_src2, div_result;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int starts       = 0;
  int s            = 0;
  bit ok0_seen, ok1_seen;

  always #5 clk = ~clk;

  div_arbiter #(.DATA_WD(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .es0_to_div_bus (es0_to_div_bus),
    .es1_to_div_bus (es1_to_div_bus),
    .div_to_es0_bus (div_to_es0_bus),
    .div_to_es1_bus (div_to_es1_bus),
    .advance        (advance),
    .flush          (flush),
    .div_start      (div_start),
    .div_mod        (div_mod),
    .div_unsigned   (div_unsigned),
    .div_src1       (div_src1),
    .div_src2       (div_src2),
    .div_done       (div_done),
    .div_result     (div_result)
  );

  // Divider model: done pulses 8 cycles after the start cycle.
  int unsigned dcnt;
  logic [31:0] dres;

  function automatic logic [31:0] refDiv(input logic m, input logic u,
                                         input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (u) return m ? (a % b) : (a / b);
    return m ? (sa % sb) : (sa / sb);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dcnt <= 0;
      dres <= '0;
    end else if (div_start) begin
      dcnt <= 8;
      dres <= refDiv(div_mod, div_unsigned, div_src1, div_src2);
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
    end
  end

  assign div_done   = (dcnt == 1);
  assign div_result = dres;

  function automatic logic [ES_TO_DIV_BUS_MD-1:0] mkReq(input logic v, input logic m,
                                                         input logic u, input logic [31:0] a,
                                                         input logic [31:0] b);
    return {v, m, u, a, b};
  endfunction

  task automatic applyStimulus(input logic [ES_TO_DIV_BUS_MD-1:0] r0,
                               input logic [ES_TO_DIV_BUS_MD-1:0] r1,
                               input logic adv, input logic fl);
    es0_to_div_bus = r0;
    es1_to_div_bus = r1;
    advance        = adv;
    flush          = fl;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to the next negedge, recording start pulses and any ok seen.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (div_start) starts++;
      if (div_to_es0_bus[0]) ok0_seen = 1'b1;
      if (div_to_es1_bus[0]) ok1_seen = 1'b1;
    end
  endtask

  logic [ES_TO_DIV_BUS_MD-1:0] ra, rb;

  initial begin
    reset = 1'b1;
    applyStimulus('0, '0, 1'b0, 1'b0);
    tick(2);
    checkOutput("rst_ok0", div_to_es0_bus, 33'h0);
    checkOutput("rst_ok1", div_to_es1_bus, 33'h0);
    checkOutput("rst_start", div_start, 1'b0);
    checkOutput("rst_src1", div_src1, 32'h0);
    reset = 1'b0;
    tick(1);

    // Lane 0 signed 100 / -7
    ra = mkReq(1'b1, 1'b0, 1'b0, 32'd100, 32'hFFFF_FFF9);
    applyStimulus(ra, '0, 1'b0, 1'b0);
    s = starts;
    tick(1);
    checkOutput("t1_start", div_start, 1'b1);
    checkOutput("t1_src1", div_src1, 32'd100);
    checkOutput("t1_src2", div_src2, 32'hFFFF_FFF9);
    checkOutput("t1_modes", {div_mod, div_unsigned}, 2'b00);
    tick(1);
    checkOutput("t1_start_pulse", div_start, 1'b0);
    tick(7);
    checkOutput("t1_ok_early", div_to_es0_bus[0], 1'b0);
    tick(1);
    checkOutput("t1_ok", div_to_es0_bus[0], 1'b1);
    checkOutput("t1_res", div_to_es0_bus[32:1], 32'hFFFF_FFF2);
    tick(3);
    checkOutput("t1_ok_held", div_to_es0_bus[0], 1'b1);
    checkOutput("t1_starts", starts - s, 1);
    applyStimulus(ra, '0, 1'b1, 1'b0);
    tick(1);
    checkOutput("t1_ok_clr", div_to_es0_bus[0], 1'b0);
    applyStimulus('0, '0, 1'b0, 1'b0);
    tick(1);

    // Both lanes at once: lane 0 unsigned 0xFFFFFFFF mod 10, lane 1 50 / 5
    ra = mkReq(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd10);
    rb = mkReq(1'b1, 1'b0, 1'b0, 32'd50, 32'd5);
    applyStimulus(ra, rb, 1'b0, 1'b0);
    s = starts;
    tick(1);
    checkOutput("t2_start0", div_start, 1'b1);
    checkOutput("t2_src0", {div_src1, div_src2}, {32'hFFFF_FFFF, 32'd10});
    checkOutput("t2_modes0", {div_mod, div_unsigned}, 2'b11);
    tick(9);
    checkOutput("t2_ok0", div_to_es0_bus, {32'd5, 1'b1});
    checkOutput("t2_start1", div_start, 1'b1);
    checkOutput("t2_src1", {div_src1, div_src2}, {32'd50, 32'd5});
    checkOutput("t2_ok1_early", div_to_es1_bus[0], 1'b0);
    tick(8);
    checkOutput("t2_ok1_still_low", div_to_es1_bus[0], 1'b0);
    checkOutput("t2_ok0_held", div_to_es0_bus[0], 1'b1);
    tick(1);
    checkOutput("t2_ok1", div_to_es1_bus, {32'd10, 1'b1});
    checkOutput("t2_two_starts", starts - s, 2);

    // Advance with both requests still asserted
    applyStimulus(ra, rb, 1'b1, 1'b0);
    tick(1);
    checkOutput("t3_oks_clr", {div_to_es0_bus[0], div_to_es1_bus[0]}, 2'b00);
    applyStimulus('0, '0, 1'b0, 1'b0);
    tick(5);
    checkOutput("t3_no_third", starts - s, 2);

    // Flush 3 cycles into BUSY0, lane 1 requests during DRAIN
    ra = mkReq(1'b1, 1'b0, 1'b0, 32'd1000, 32'd3);
    rb = mkReq(1'b1, 1'b1, 1'b0, 32'hFFFF_FFAD, 32'd9);
    applyStimulus(ra, '0, 1'b0, 1'b0);
    s = starts;
    ok0_seen = 1'b0;
    ok1_seen = 1'b0;
    tick(4);
    applyStimulus('0, '0, 1'b0, 1'b1);
    tick(1);
    applyStimulus('0, '0, 1'b0, 1'b0);
    tick(1);
    applyStimulus('0, rb, 1'b0, 1'b0);
    tick(4);
    checkOutput("t4_drain_starts", starts - s, 1);
    checkOutput("t4_no_ok", {ok0_seen, ok1_seen}, 2'b00);
    checkOutput("t4_res0_kept", div_to_es0_bus[32:1], 32'd5);
    tick(1);
    checkOutput("t4_relaunch", div_start, 1'b1);
    checkOutput("t4_src", {div_mod, div_src1, div_src2}, {1'b1, 32'hFFFF_FFAD, 32'd9});
    tick(9);
    checkOutput("t4_ok1", div_to_es1_bus, {32'hFFFF_FFFE, 1'b1});
    applyStimulus('0, rb, 1'b1, 1'b0);
    tick(1);
    applyStimulus('0, '0, 1'b0, 1'b0);
    checkOutput("t4_ok1_clr", div_to_es1_bus[0], 1'b0);
    tick(1);

    // Flush coincident with div_done
    ra = mkReq(1'b1, 1'b0, 1'b1, 32'd7, 32'd2);
    applyStimulus(ra, '0, 1'b0, 1'b0);
    ok0_seen = 1'b0;
    tick(9);
    applyStimulus('0, '0, 1'b0, 1'b1);
    tick(1);
    rb = mkReq(1'b1, 1'b0, 1'b1, 32'd200, 32'd7);
    applyStimulus('0, rb, 1'b0, 1'b0);
    checkOutput("t5_res0_kept", div_to_es0_bus, {32'd5, 1'b0});
    checkOutput("t5_no_ok0", ok0_seen, 1'b0);
    tick(1);
    checkOutput("t5_idle_launch", div_start, 1'b1);
    checkOutput("t5_src", {div_unsigned, div_src1}, {1'b1, 32'd200});
    tick(4);

    // Asynchronous reset in the middle of BUSY1
    #2;
    reset = 1'b1;
    applyStimulus('0, '0, 1'b0, 1'b0);
    #1;
    checkOutput("t6_src", {div_src1, div_src2}, 64'h0);
    checkOutput("t6_flags", {div_start, div_mod, div_unsigned}, 3'b000);
    checkOutput("t6_bus0", div_to_es0_bus, 33'h0);
    checkOutput("t6_bus1", div_to_es1_bus, 33'h0);
    tick(2);
    reset = 1'b0;
    tick(1);
    rb = mkReq(1'b1, 1'b0, 1'b0, 32'd64, 32'd8);
    applyStimulus('0, rb, 1'b0, 1'b0);
    s = starts;
    tick(1);
    checkOutput("t6_start", div_start, 1'b1);
    checkOutput("t6_src1", div_src1, 32'd64);
    tick(8);
    checkOutput("t6_ok_early", div_to_es1_bus[0], 1'b0);
    tick(1);
    checkOutput("t6_ok", div_to_es1_bus, {32'd8, 1'b1});
    checkOutput("t6_starts", starts - s, 1);
    applyStimulus('0, '0, 1'b0, 1'b0);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
